// File: rtl/jenc_bit_pack.sv
// jenc_bit_pack: packs MSB-first variable-length bit fields into big-endian
// output words. It inserts 0x00 after each 0xFF byte (optional), pads the last
// partial byte of a frame with 1s, and keeps a per-frame byte count.
module jenc_bit_pack #(
  parameter int IN_W      = 52,
  parameter int LEN_W     = $clog2(IN_W+1),
  parameter int OUT_W     = 32,
  parameter int BUF_BYTES = 16,
  parameter int STUFF     = 1,
  localparam int BPC      = OUT_W/8,
  localparam int OBW      = $clog2(BPC)+1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic             in_tlast,
  input  logic             in_valid,
  output logic             in_hold,
  output logic [OUT_W-1:0] out_data,
  output logic [OBW-1:0]   out_bytes,
  output logic             out_tlast,
  output logic             out_valid,
  input  logic             out_hold,
  output logic [31:0]      frame_bytes
);
  localparam int ACC_W = IN_W + 8 + 8*BPC;
  // One spare byte of storage: padding a tlast beat can round the fill up
  // past ACC_W. The hold threshold still uses ACC_W.
  localparam int AW = ACC_W + 8;
  localparam int HW = $clog2(AW+1);
  localparam int PW = $clog2(BUF_BYTES);
  localparam int CW = PW + 1;

  logic [AW-1:0] acc;          // first bit to send sits at acc[AW-1]
  logic [HW-1:0] held;
  logic [7:0]    buf_mem [BUF_BYTES];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          flush_pend;
  logic [31:0]   fcnt;

  logic          accept, pop, fin_ok;
  int            nx, nw, hx, pad, tot;
  logic [7:0]    wbytes [2*BPC];
  logic [AW-1:0] acc_next, dpad;
  logic [HW-1:0] held_next;
  logic [CW-1:0] count_next;

  assign in_hold = flush_pend || (int'(held) + IN_W > ACC_W);
  assign accept  = in_valid && !in_hold;

  // Byte extraction from the accumulator top and append of the new beat
  always_comb begin
    logic [7:0] b;
    int need, free;
    logic go;
    nx = 0; nw = 0; go = 1'b1; b = '0; need = 1;
    free = BUF_BYTES - int'(count);
    for (int k = 0; k < 2*BPC; k++) wbytes[k] = '0;
    for (int i = 0; i < BPC; i++) begin
      b = acc[AW-1-8*i -: 8];
      need = (STUFF != 0 && b == 8'hFF) ? 2 : 1;
      if (go && int'(held) >= 8*(i+1) && nw + need <= free) begin
        wbytes[nw] = b;
        if (need == 2) wbytes[nw+1] = 8'h00;
        nw = nw + need;
        nx = nx + 1;
      end else begin
        go = 1'b0;
      end
    end
    hx  = int'(held) - 8*nx;
    tot = hx + int'(in_len);
    pad = in_tlast ? ((8 - (tot % 8)) % 8) : 0;
    // masked data followed by pad 1s, then aligned just below the kept bits
    dpad = ((((AW'(1) << in_len) - AW'(1)) & AW'(in_data)) << pad) | ((AW'(1) << pad) - AW'(1));
    acc_next  = acc << (8*nx);
    held_next = HW'(hx);
    if (accept) begin
      acc_next  = acc_next | (dpad << (AW - tot - pad));
      held_next = HW'(tot + pad);
    end
  end

  // Output word straight from the registered byte buffer head
  always_comb begin
    fin_ok    = flush_pend && (held == '0);
    out_valid = (int'(count) >= BPC) || fin_ok;
    out_tlast = fin_ok && (int'(count) <= BPC);
    out_bytes = '0;
    if (out_valid) out_bytes = (int'(count) >= BPC) ? OBW'(BPC) : OBW'(count);
    out_data = '0;
    for (int i = 0; i < BPC; i++)
      if (i < int'(out_bytes)) out_data[OUT_W-1-8*i -: 8] = buf_mem[rd_ptr + PW'(i)];
    pop        = out_valid && !out_hold;
    count_next = CW'(int'(count) + nw - (pop ? int'(out_bytes) : 0));
  end

  // Byte buffer storage; contents beyond count are never read out
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2*BPC; k++)
      if (k < nw) buf_mem[wr_ptr + PW'(k)] <= wbytes[k];
  end

  // Accumulator, buffer pointers, flush state and frame byte counter
  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      held        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      flush_pend  <= 1'b0;
      fcnt        <= '0;
      frame_bytes <= '0;
    end else begin
      acc    <= acc_next;
      held   <= held_next;
      count  <= count_next;
      wr_ptr <= wr_ptr + PW'(nw);
      if (pop) rd_ptr <= rd_ptr + PW'(out_bytes);
      if (accept && in_tlast) flush_pend <= 1'b1;
      else if (pop && out_tlast) flush_pend <= 1'b0;
      if (pop) begin
        if (out_tlast) begin
          frame_bytes <= fcnt + 32'(out_bytes);
          fcnt        <= '0;
        end else begin
          fcnt <= fcnt + 32'(out_bytes);
        end
      end
    end
  end

  // A length beyond the field width would corrupt the accumulator
  a_len_legal: assert property (@(posedge clk) disable iff (reset)
    in_valid |-> (int'(in_len) <= IN_W))
    else $fatal(1, "jenc_bit_pack: in_len exceeds IN_W");
endmodule

// File: tb/tb_jenc_bit_pack.sv
// Scoreboard bench for jenc_bit_pack: a 32-bit stuffing instance (A) and a
// 64-bit non-stuffing instance (B), directed frames with hand-computed words.
module tb_jenc_bit_pack;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    int          bytes;
    bit          last;
    int          fb;
  } exp_t;

  exp_t qa[$], qb[$];
  int   n_cmp = 0, n_bad = 0;
  bit   hold_rand = 0;
  bit   saw_hold = 0;

  // instance A: OUT_W=32, STUFF=1
  logic        rst_a;
  logic [51:0] a_d;
  logic [5:0]  a_l;
  logic        a_t, a_v, a_ih, a_ot, a_ov, a_oh;
  logic [31:0] a_od, a_fb;
  logic [2:0]  a_ob;
  // instance B: OUT_W=64, STUFF=0
  logic        rst_b;
  logic [51:0] b_d;
  logic [5:0]  b_l;
  logic        b_t, b_v, b_ih, b_ot, b_ov, b_oh;
  logic [63:0] b_od;
  logic [31:0] b_fb;
  logic [3:0]  b_ob;

  jenc_bit_pack #(.OUT_W(32), .STUFF(1)) dut_a (
    .clk(clk), .reset(rst_a), .in_data(a_d), .in_len(a_l), .in_tlast(a_t),
    .in_valid(a_v), .in_hold(a_ih), .out_data(a_od), .out_bytes(a_ob),
    .out_tlast(a_ot), .out_valid(a_ov), .out_hold(a_oh), .frame_bytes(a_fb));

  jenc_bit_pack #(.OUT_W(64), .STUFF(0)) dut_b (
    .clk(clk), .reset(rst_b), .in_data(b_d), .in_len(b_l), .in_tlast(b_t),
    .in_valid(b_v), .in_hold(b_ih), .out_data(b_od), .out_bytes(b_ob),
    .out_tlast(b_ot), .out_valid(b_ov), .out_hold(b_oh), .frame_bytes(b_fb));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit which, input logic [63:0] d, input int nb, input bit last, input int fb);
    exp_t e;
    e.data = d; e.bytes = nb; e.last = last; e.fb = fb;
    if (!which) qa.push_back(e); else qb.push_back(e);
  endtask

  // called at a negedge; returns at the negedge after acceptance
  task automatic send(input bit which, input logic [51:0] d, input int len, input bit last);
    int t;
    t = 0;
    if (!which) begin a_d = d; a_l = 6'(len); a_t = last; a_v = 1'b1; end
    else        begin b_d = d; b_l = 6'(len); b_t = last; b_v = 1'b1; end
    while ((!which ? a_ih : b_ih) && t < 4000) begin @(negedge clk); t++; end
    if (t >= 4000) begin n_cmp++; n_bad++; $display("FAIL send_timeout: in_hold stuck at 1, expected 0"); end
    @(negedge clk);
    if (!which) begin a_v = 1'b0; a_t = 1'b0; end
    else        begin b_v = 1'b0; b_t = 1'b0; end
  endtask

  task automatic drain(input bit which);
    int t;
    t = 0;
    while ((!which ? qa.size() : qb.size()) != 0 && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) begin n_cmp++; n_bad++; $display("FAIL drain_timeout: %0d words outstanding, expected 0", !which ? qa.size() : qb.size()); end
    repeat (4) @(negedge clk);
  endtask

  // random downstream stall on A
  initial begin
    forever begin
      @(posedge clk); #1;
      a_oh = hold_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // monitor A: pops and compares on each accepted word, checks hold stability
  initial begin : mon_a
    bit pv, fbchk;
    logic [35:0] prev;
    int fbexp;
    exp_t e;
    pv = 0; fbchk = 0; prev = '0; fbexp = 0;
    forever begin
      @(negedge clk);
      if (a_v && a_ih) saw_hold = 1;
      if (rst_a) begin pv = 0; fbchk = 0; continue; end
      if (fbchk) begin check("a_frame_bytes", 64'(a_fb), 64'(fbexp)); fbchk = 0; end
      if (pv) begin
        check("a_valid_under_hold", 64'(a_ov), 64'd1);
        check("a_stable_under_hold", 64'({a_od, a_ob, a_ot}), 64'(prev));
      end
      pv = a_ov && a_oh;
      prev = {a_od, a_ob, a_ot};
      if (a_ov && !a_oh) begin
        if (qa.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_unexpected_word: got %0h bytes %0d, expected none", a_od, a_ob);
        end else begin
          e = qa.pop_front();
          check("a_data", 64'(a_od), 64'(e.data[31:0]));
          check("a_bytes", 64'(a_ob), 64'(e.bytes));
          check("a_tlast", 64'(a_ot), 64'(e.last));
          if (e.last) begin fbchk = 1; fbexp = e.fb; end
        end
      end
    end
  end

  // monitor B
  initial begin : mon_b
    bit fbchk;
    int fbexp;
    exp_t e;
    fbchk = 0; fbexp = 0;
    forever begin
      @(negedge clk);
      if (rst_b) begin fbchk = 0; continue; end
      if (fbchk) begin check("b_frame_bytes", 64'(b_fb), 64'(fbexp)); fbchk = 0; end
      if (b_ov && !b_oh) begin
        if (qb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_unexpected_word: got %0h bytes %0d, expected none", b_od, b_ob);
        end else begin
          e = qb.pop_front();
          check("b_data", b_od, e.data);
          check("b_bytes", 64'(b_ob), 64'(e.bytes));
          check("b_tlast", 64'(b_ot), 64'(e.last));
          if (e.last) begin fbchk = 1; fbexp = e.fb; end
        end
      end
    end
  end

  initial begin
    rst_a = 1; rst_b = 1; a_oh = 0; b_oh = 0;
    a_d = '0; a_l = '0; a_t = 0; a_v = 0;
    b_d = '0; b_l = '0; b_t = 0; b_v = 0;
    repeat (3) @(negedge clk);
    check("rst_a_outputs", 64'({a_ih, a_ov, a_od, a_ob, a_ot}), 64'd0);
    check("rst_a_frame_bytes", 64'(a_fb), 64'd0);
    check("rst_b_outputs", {b_ih, b_ov, b_ob, b_ot}, 64'd0);
    check("rst_b_data", b_od, 64'd0);
    rst_a = 0; rst_b = 0;
    @(negedge clk);
    check("idle_a_valid", 64'(a_ov), 64'd0);

    // FF then 12 with tlast: FF is stuffed
    push(0, 64'hFF001200, 3, 1, 3);
    send(0, 52'hFF, 8, 0);
    send(0, 52'h12, 8, 1);
    drain(0);

    // partial bytes padded with 1s; 111+11111 = FF gets stuffed
    push(0, 64'hBF000000, 1, 1, 1);
    send(0, 52'h5, 3, 1);
    drain(0);
    push(0, 64'hFF000000, 2, 1, 2);
    send(0, 52'h7, 3, 1);
    drain(0);

    // 40 all-ones beats under random stall: 260 FF -> 520 bytes
    for (int i = 0; i < 129; i++) push(0, 64'hFF00FF00, 4, 0, 0);
    push(0, 64'hFF00FF00, 4, 1, 520);
    saw_hold = 0;
    hold_rand = 1;
    for (int i = 0; i < 40; i++) send(0, {52{1'b1}}, 52, i == 39);
    drain(0);
    hold_rand = 0;
    @(negedge clk);
    check("a_in_hold_seen", 64'(saw_hold), 64'd1);

    // 64-bit, no stuffing: 13 x A5
    push(1, 64'hA5A5A5A5A5A5A5A5, 8, 0, 0);
    push(1, 64'hA5A5A5A5A5000000, 5, 1, 13);
    for (int i = 0; i < 13; i++) send(1, 52'hA5, 8, i == 12);
    drain(1);

    // empty frame
    push(0, 64'h0, 0, 1, 0);
    send(0, 52'h0, 0, 1);
    drain(0);

    // zero-length non-last beat has no effect
    push(0, 64'h3C000000, 1, 1, 1);
    send(0, 52'h0, 0, 0);
    send(0, 52'h3C, 8, 0);
    send(0, 52'h0, 0, 1);
    drain(0);

    // abort a frame by reset, then a clean one-byte frame
    send(0, 52'h12, 8, 0);
    send(0, 52'h34, 8, 0);
    send(0, 52'h56, 8, 0);
    rst_a = 1;
    @(negedge clk);
    rst_a = 0;
    @(negedge clk);
    check("a_post_reset_fb", 64'(a_fb), 64'd0);
    check("a_post_reset_valid", 64'(a_ov), 64'd0);
    push(0, 64'h55000000, 1, 1, 1);
    send(0, 52'h55, 8, 1);
    drain(0);
    repeat (20) @(negedge clk);
    check("a_queue_empty", 64'(qa.size()), 64'd0);
    check("b_queue_empty", 64'(qb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
